// File: rtl/phase_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_pkg
// Description : Shared types and default widths for the per-voice phase
//               accumulator (phase_gen).
// Revision    : 1.0 - initial release
// ============================================================================
package phase_pkg;

  // Width of the waveform address consumed by the oscillator generators
  localparam int PHASE_W = 9;

  // Default accumulator and tuning-word widths
  localparam int DEF_ACC_W = 24;
  localparam int DEF_INC_W = 24;

  // Voice gating state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } phase_state_t;

endpackage : phase_pkg
`default_nettype wire

// File: rtl/phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : phase_gen
// Description : Per-voice phase accumulator. Advances a wide accumulator by
//               a per-note increment on each sample tick and presents the top
//               PHASE_W bits as the waveform address. Emits an address strobe,
//               a wrap flag and a sample strobe delayed one cycle to line up
//               with the generator's registered output.
//               Optional hard sync is enabled by defining PHASE_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_gen
  import phase_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int INC_W = DEF_INC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               note_on,
  input  logic               note_off,
  input  logic               freq_load,
  input  logic [INC_W-1:0]   freq_inc,
`ifdef PHASE_SYNC_EN
  input  logic               sync_in,
`endif
  output logic [PHASE_W-1:0] addr_full,
  output logic               addr_valid,
  output logic               sample_valid,
  output logic               wrap,
  output logic               active
);

  // Zero-extension width for the increment inside the carry-producing add
  localparam int EXT_W = ACC_W + 1 - INC_W;

  phase_state_t     state;
  logic [ACC_W-1:0] acc;
  logic [INC_W-1:0] inc;

  // Sum including carry out; always uses the increment held before this edge
  logic [ACC_W:0]   sum;
  assign sum = {1'b0, acc} + {{EXT_W{1'b0}}, inc};

`ifdef PHASE_SYNC_EN
  logic sync_pend;
  // A pending sync or a sync arriving with the tick restarts the phase
  logic sync_now;
  assign sync_now = sync_pend | sync_in;
`endif

  // Voice FSM: gating, phase accumulation and registered address/strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      addr_full  <= '0;
      addr_valid <= 1'b0;
      wrap       <= 1'b0;
      active     <= 1'b0;
`ifdef PHASE_SYNC_EN
      sync_pend  <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below
      addr_valid <= 1'b0;
      wrap       <= 1'b0;

      if (note_on) begin
        // Restart from phase 0 regardless of current state; a coincident
        // tick emits the restart sample at address 0
        state      <= RUN;
        active     <= 1'b1;
        acc        <= '0;
        addr_full  <= '0;
        addr_valid <= sample_tick;
`ifdef PHASE_SYNC_EN
        sync_pend  <= 1'b0;
`endif
      end else if (note_off) begin
        // Gate the voice; a coincident tick produces no sample
        state     <= IDLE;
        active    <= 1'b0;
        acc       <= '0;
        addr_full <= '0;
`ifdef PHASE_SYNC_EN
        sync_pend <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            acc       <= '0;
            addr_full <= '0;
            active    <= 1'b0;
          end
          RUN: begin
            active <= 1'b1;
            if (sample_tick) begin
              addr_valid <= 1'b1;
`ifdef PHASE_SYNC_EN
              if (sync_now) begin
                acc       <= '0;
                addr_full <= '0;
                wrap      <= 1'b0;
                sync_pend <= 1'b0;
              end else begin
                acc       <= sum[ACC_W-1:0];
                addr_full <= sum[ACC_W-1 -: PHASE_W];
                wrap      <= sum[ACC_W];
              end
`else
              acc       <= sum[ACC_W-1:0];
              addr_full <= sum[ACC_W-1 -: PHASE_W];
              wrap      <= sum[ACC_W];
`endif
            end
`ifdef PHASE_SYNC_EN
            else if (sync_in) begin
              sync_pend <= 1'b1;
            end
`endif
          end
          default: begin
            // Unused encoding: recover to a quiet idle voice
            state     <= IDLE;
            active    <= 1'b0;
            acc       <= '0;
            addr_full <= '0;
          end
        endcase
      end
    end
  end

  // Tuning word: loaded on note start or glide update; the add above reads
  // the pre-edge value, so a load coincident with a tick applies next tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc <= '0;
    end else if (note_on || freq_load) begin
      inc <= freq_inc;
    end
  end

  // One-cycle delay aligning the sample strobe with the generator's output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= addr_valid;
    end
  end

endmodule : phase_gen
`default_nettype wire

// File: doc/phase_gen.md
# phase_gen

Per-voice phase accumulator driving the 9-bit waveform address consumed by the oscillator lookup/generator blocks (saw, square, sine). On each sample-rate strobe it advances a wide accumulator by a per-note frequency increment and presents the top 9 bits as `addr_full`. It also emits strobes aligned to the generator's one-cycle registered output, so downstream mixing knows when a fresh sample is ready. Note on/off control gates the voice.

## Interface
- `ACC_W`, 24, accumulator width in bits; `addr_full` = `acc[ACC_W-1 -: 9]`.
- `INC_W`, 24, frequency increment width; must be ≤ `ACC_W`, zero-extended into the add.
- `clk` input 1: single system clock, all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sample_tick` input 1: one-cycle strobe at the audio sample rate.
- `note_on` input 1: one-cycle pulse; loads `freq_inc`, restarts phase, enters RUN.
- `note_off` input 1: one-cycle pulse; returns to IDLE.
- `freq_load` input 1: one-cycle pulse; loads `freq_inc` without a phase restart (glide/vibrato).
- `freq_inc` input INC_W: tuning word, sampled only on `note_on`/`freq_load`.
- `sync_in` input 1: hard-sync pulse; present only under `PHASE_SYNC_EN`.
- `addr_full` output 9: phase address to the waveform generator.
- `addr_valid` output 1: `addr_full` updated this cycle.
- `sample_valid` output 1: `addr_valid` delayed one cycle; aligned with the generator's `data_out`.
- `wrap` output 1: accumulator carried out on this update; coincident with `addr_valid`.
- `active` output 1: high in RUN.

## Operation
- States: IDLE, RUN; 2-bit enum.
- IDLE:
  - `acc` held at 0, `addr_full`=0.
  - `addr_valid`/`wrap` never assert; `sample_tick` ignored.
- IDLE→RUN on `note_on`:
  - `inc` <= `freq_inc`, `acc` <= 0.
- RUN, on `sample_tick`:
  - `{carry, acc}` <= `acc + inc`, mod 2^ACC_W.
  - `addr_full` <= new `acc[ACC_W-1 -: 9]`.
  - `addr_valid` <= 1, `wrap` <= carry.
- RUN→IDLE on `note_off`:
  - `acc` and `addr_full` cleared, `inc` retained.
- `freq_load` in any state updates `inc`; it takes effect on the next add.
- Priority, same cycle:
  - `note_on` beats `note_off` and `freq_load`.
  - `note_on` with `sample_tick`: `acc`=0, `addr_full`=0, `addr_valid`=1, `wrap`=0. The restart sample is emitted.
  - `note_off` with `sample_tick`: no sample; IDLE.
  - `freq_load` with `sample_tick`: the add uses the old `inc`.
- `inc`=0 in RUN: phase frozen, but `addr_valid` still pulses each tick.
- Reset:
  - Asynchronous and immediate; valid mid-operation.
  - State IDLE, `acc`=0, `inc`=0.
  - Outputs `addr_full`=0, `addr_valid`=0, `sample_valid`=0, `wrap`=0, `active`=0.

## Timing
- `sample_tick` high in cycle N → `addr_full`, `addr_valid`, `wrap` valid in cycle N+1.
- The waveform generator's `data_out` is valid in N+2; `sample_valid` is high in N+2.
- `addr_valid`, `wrap`, `sample_valid` are exactly one cycle wide.
- `sample_tick` may arrive back-to-back, one per cycle. Each tick produces one update, with no loss.
- `active` rises the cycle after `note_on` and falls the cycle after `note_off`.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `PHASE_SYNC_EN` defined:
  - `sync_in` port exists.
  - A `sync_in` pulse in RUN sets `sync_pend`. The next `sample_tick` loads `acc` <= 0 instead of adding: `addr_full`=0, `addr_valid`=1, `wrap`=0. That tick clears `sync_pend`.
  - `sync_in` with `sample_tick` in the same cycle applies on that tick.
  - `note_on`, `note_off`, and reset clear `sync_pend`.
  - `sync_in` in IDLE is ignored.
- `PHASE_SYNC_EN` undefined: no `sync_in` port, no `sync_pend` register; free-running behaviour only.

## Structure
- `phase_pkg` holds:
  - `PHASE_W`=9, matching the waveform address width.
  - `phase_state_t` enum {IDLE, RUN}.
  - Default `ACC_W`/`INC_W` localparams.
- Single module; no sub-module. The `sample_valid` delay is one flop inside `phase_gen`.

## Test plan
- Reset/idle:
  - Assert `rst_n`=0 mid-RUN → all outputs 0 asynchronously.
  - Release, pulse `sample_tick` ×4 → no `addr_valid`, `addr_full`=0.
- Unit step:
  - `note_on` with `freq_inc`=0x008000, then ticks 1..3 → `addr_full` = 1, 2, 3.
  - `sample_valid` one cycle after each `addr_valid`.
- Wrap:
  - `freq_inc`=0x400000 → `addr_full` sequence 128, 256, 384, 0.
  - `wrap`=1 only on the 0 sample.
  - With 0x008000 → `wrap` on tick 512, `addr_full`=0.
- Collisions:
  - `note_on` + `sample_tick` same cycle → `addr_full`=0, `addr_valid`=1, `wrap`=0.
  - `note_on` + `note_off` same cycle → `active`=1.
  - `note_off` + `sample_tick` → no `addr_valid`, `active`=0.
- Glide:
  - At `addr_full`=10 with `inc`=0x008000, `freq_load` 0x010000 → next ticks give 11 (old `inc` on a coincident tick, else 12), then +2 per tick; no restart.
  - Back-to-back ticks for 8 cycles → 8 `addr_valid` pulses.
- Sync (`PHASE_SYNC_EN`):
  - At `addr_full`=200, pulse `sync_in`; next tick → `addr_full`=0, `wrap`=0.
  - Following tick → 1 with `inc`=0x008000.
  - `sync_in` in IDLE → no effect.
